// File: rtl/cgra_kernel_launcher_if.sv
// Register port and CGRA start/done handshake bundle for cgra_kernel_launcher.
// The master side is the host plus the CGRA core; the slave side is the launcher.
interface cgra_kernel_launcher_if #(
    parameter int DWIDTH = 32
);
    logic              Cfg_Wen;
    logic              Cfg_Ren;
    logic [1:0]        Cfg_Addr;
    logic [DWIDTH-1:0] Cfg_Wdata;
    logic [DWIDTH-1:0] Cfg_Rdata;
    logic              Computation_Start;
    logic              Computation_Done;
    logic              Launcher_Busy;
    logic              Run_Done;
    logic [DWIDTH-1:0] Iter_Index;

    modport master (
        output Cfg_Wen, Cfg_Ren, Cfg_Addr, Cfg_Wdata, Computation_Done,
        input  Cfg_Rdata, Computation_Start, Launcher_Busy, Run_Done, Iter_Index
    );

    modport slave (
        input  Cfg_Wen, Cfg_Ren, Cfg_Addr, Cfg_Wdata, Computation_Done,
        output Cfg_Rdata, Computation_Start, Launcher_Busy, Run_Done, Iter_Index
    );
endinterface

// File: rtl/cgra_kernel_launcher.sv
// Host-side sequencer for the CGRA core: runs the 4-phase Start/Done handshake
// ITER_NUM times after a GO write, with a bounded wait in each phase, a busy
// cycle counter, sticky DONE/ERR bits and an abort path.
module cgra_kernel_launcher #(
    parameter int DWIDTH         = 32,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    cgra_kernel_launcher_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_ITER   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CYCLES = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE,
        S_GAP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] iter_num_q, iter_num_d;
    logic [DWIDTH-1:0] iter_idx_q, iter_idx_d;
    logic [DWIDTH-1:0] cycles_q, cycles_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              wr_ctrl, go, abort, clr, busy;
    logic [DWIDTH-1:0] iter_idx_inc;

    assign wr_ctrl      = bus.Cfg_Wen && (bus.Cfg_Addr == ADDR_CTRL);
    assign go           = wr_ctrl && bus.Cfg_Wdata[0];
    assign abort        = wr_ctrl && bus.Cfg_Wdata[1];
    assign clr          = wr_ctrl && bus.Cfg_Wdata[2];
    assign busy         = (state_q == S_ASSERT) || (state_q == S_RELEASE) ||
                          (state_q == S_GAP)    || (state_q == S_FINISH);
    assign iter_idx_inc = iter_idx_q + DWIDTH'(1);

    // Next-state, datapath and read-mux logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        iter_num_d = iter_num_q;
        iter_idx_d = iter_idx_q;
        cycles_d   = cycles_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        done_d     = done_q;
        err_d      = err_q;
        rdata_d    = rdata_q;

        if (clr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        if (busy && (cycles_q != '1)) begin
            cycles_d = cycles_q + DWIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.Cfg_Wen && (bus.Cfg_Addr == ADDR_ITER)) begin
                    iter_num_d = bus.Cfg_Wdata;
                end
                // ABORT written together with GO keeps the block idle.
                if (go && !abort) begin
                    cycles_d   = '0;
                    iter_idx_d = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    tmo_d      = '0;
                    state_d    = (iter_num_q == '0) ? S_FINISH : S_ASSERT;
                end
            end
            S_ASSERT: begin
                // Done is checked before the limit so a same-cycle acknowledge wins.
                if (abort) begin
                    state_d = S_ERROR;
                end else if (bus.Computation_Done) begin
                    tmo_d   = '0;
                    state_d = S_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RELEASE: begin
                if (abort) begin
                    state_d = S_ERROR;
                end else if (!bus.Computation_Done) begin
                    iter_idx_d = iter_idx_inc;
                    if (iter_idx_inc == iter_num_q) begin
                        state_d = S_FINISH;
                    end else if (GAP_CYCLES == 0) begin
                        tmo_d   = '0;
                        state_d = S_ASSERT;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_ERROR;
                end else if (gap_q == GAP_LAST) begin
                    tmo_d   = '0;
                    state_d = S_ASSERT;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_FINISH: begin
                if (abort) begin
                    state_d = S_ERROR;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Read data is captured only on a read strobe and held otherwise.
        if (bus.Cfg_Ren) begin
            case (bus.Cfg_Addr)
                ADDR_CTRL:   rdata_d = '0;
                ADDR_ITER:   rdata_d = iter_num_q;
                ADDR_STATUS: rdata_d = DWIDTH'({iter_idx_q[15:0], 13'b0, err_q, done_q, busy});
                ADDR_CYCLES: rdata_d = cycles_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!Resetn) begin
            state_q    <= S_IDLE;
            iter_num_q <= '0;
            iter_idx_q <= '0;
            cycles_q   <= '0;
            rdata_q    <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_num_q <= iter_num_d;
            iter_idx_q <= iter_idx_d;
            cycles_q   <= cycles_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Start is also gated by reset so a mid-run reset drops it without waiting for the edge.
    assign bus.Computation_Start = (state_q == S_ASSERT) && Resetn;
    assign bus.Launcher_Busy     = busy;
    assign bus.Run_Done          = (state_q == S_FINISH);
    assign bus.Iter_Index        = iter_idx_q;
    assign bus.Cfg_Rdata         = rdata_q;

endmodule

// File: tb/tb_cgra_kernel_launcher.sv
// Directed bench for cgra_kernel_launcher: a CGRA responder model answers the
// handshake, a monitor compares Start pulse widths and gaps against a queue of
// expected values, and register reads are checked against a read scoreboard.
module tb_cgra_kernel_launcher;

    localparam int DW   = 32;
    localparam int TMO  = 16;
    localparam int GAP  = 2;
    localparam int RISE = 5;
    localparam int FALL = 2;

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_ITER = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_CYC  = 2'd3;

    logic Clk    = 1'b0;
    logic Resetn = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    cgra_kernel_launcher_if #(.DWIDTH(DW)) bus();

    cgra_kernel_launcher #(
        .DWIDTH         (DW),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    // Scoreboard queues.
    int          exp_w_q[$];
    int          exp_g_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_tag_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // CGRA responder: raises Done RISE cycles after Start rises, drops it FALL
    // cycles after Start falls; rsp_en=0 never answers, stale forces Done high.
    bit rsp_en = 1'b1;
    bit stale  = 1'b0;
    int hi_cnt = 0;
    int lo_cnt = 0;

    initial begin
        bus.Computation_Done = 1'b0;
        forever begin
            @(negedge Clk);
            if (stale) begin
                bus.Computation_Done = 1'b1;
                hi_cnt = 0;
                lo_cnt = 0;
            end else if (bus.Computation_Start && !bus.Computation_Done) begin
                lo_cnt = 0;
                if (rsp_en) begin
                    hi_cnt++;
                    if (hi_cnt >= RISE) begin
                        bus.Computation_Done = 1'b1;
                        hi_cnt = 0;
                    end
                end
            end else if (!bus.Computation_Start && bus.Computation_Done) begin
                hi_cnt = 0;
                lo_cnt++;
                if (lo_cnt >= FALL) begin
                    bus.Computation_Done = 1'b0;
                    lo_cnt = 0;
                end
            end else begin
                hi_cnt = 0;
                lo_cnt = 0;
            end
        end
    end

    // Monitor: Start pulse widths and in-run gaps, Run_Done pulse count.
    int hi_w = 0;
    int lo_w = 0;
    int n_rise = 0;
    int n_rd = 0;
    int exp_v;
    bit gap_open = 1'b0;
    bit start_prev = 1'b0;

    always @(negedge Clk) begin
        if (bus.Run_Done) n_rd++;
        if (bus.Computation_Start) begin
            if (!start_prev) begin
                n_rise++;
                if (gap_open) begin
                    exp_v = (exp_g_q.size() > 0) ? exp_g_q.pop_front() : -1;
                    check("start_gap", lo_w, exp_v);
                end
                hi_w = 0;
                gap_open = 1'b0;
            end
            hi_w++;
        end else begin
            if (start_prev) begin
                exp_v = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : -1;
                check("start_width", hi_w, exp_v);
                gap_open = bus.Launcher_Busy;
                lo_w = 0;
            end
            if (!bus.Launcher_Busy) gap_open = 1'b0;
            if (gap_open) lo_w++;
        end
        start_prev = bus.Computation_Start;
    end

    // All tasks start and end just after a falling edge.
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.Cfg_Wen   = 1'b1;
        bus.Cfg_Addr  = a;
        bus.Cfg_Wdata = d;
        @(negedge Clk);
        bus.Cfg_Wen   = 1'b0;
        bus.Cfg_Wdata = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, input logic [31:0] exp, input string tag);
        bus.Cfg_Ren  = 1'b1;
        bus.Cfg_Addr = a;
        rd_exp_q.push_back(exp);
        rd_tag_q.push_back(tag);
        @(negedge Clk);
        bus.Cfg_Ren = 1'b0;
        check(rd_tag_q.pop_front(), bus.Cfg_Rdata, rd_exp_q.pop_front());
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((bus.Launcher_Busy || bus.Run_Done) && (k < budget)) begin
            @(negedge Clk);
            k++;
        end
        if (k >= budget) check("wait_idle_budget", {bus.Launcher_Busy, bus.Run_Done}, 0);
        repeat (2) @(negedge Clk);
    endtask

    task automatic push_run(input int pulses, input int width);
        repeat (pulses) exp_w_q.push_back(width);
        repeat (pulses - 1) exp_g_q.push_back(FALL + GAP);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 time units");
        $fatal(1, "watchdog expired");
    end

    int rd0, r0, k;
    bit prev_s;
    int falls;

    initial begin
        bus.Cfg_Wen   = 1'b0;
        bus.Cfg_Ren   = 1'b0;
        bus.Cfg_Addr  = '0;
        bus.Cfg_Wdata = '0;
        Resetn = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset state.
        check("rst_start", bus.Computation_Start, 0);
        check("rst_busy", bus.Launcher_Busy, 0);
        check("rst_run_done", bus.Run_Done, 0);
        check("rst_iter_index", bus.Iter_Index, 0);
        check("rst_rdata", bus.Cfg_Rdata, 0);
        Resetn = 1'b1;
        @(negedge Clk);
        read_reg(A_ITER, 32'd0, "rst_iter_num");
        read_reg(A_STAT, 32'd0, "rst_status");
        read_reg(A_CYC, 32'd0, "rst_cycles");

        // Three iterations with the normal responder.
        write_reg(A_ITER, 32'd3);
        read_reg(A_ITER, 32'd3, "iter_num_rd");
        rd0 = n_rd;
        r0  = n_rise;
        push_run(3, RISE);
        write_reg(A_CTRL, 32'h1);
        check("go_to_start_latency", bus.Computation_Start, 1);
        check("busy_in_run", bus.Launcher_Busy, 1);
        wait_idle(200);
        check("t1_start_pulses", n_rise - r0, 3);
        check("t1_run_done_pulses", n_rd - rd0, 1);
        read_reg(A_STAT, 32'h0003_0002, "t1_status");
        read_reg(A_CTRL, 32'd0, "ctrl_reads_zero");
        read_reg(A_CYC, 32'(3 * (RISE + FALL) + 2 * GAP + 1), "t1_cycles");
        @(negedge Clk);
        check("rdata_hold", bus.Cfg_Rdata, 32'(3 * (RISE + FALL) + 2 * GAP + 1));

        // Zero iterations: straight to FINISH.
        write_reg(A_ITER, 32'd0);
        rd0 = n_rd;
        r0  = n_rise;
        write_reg(A_CTRL, 32'h1);
        check("iter0_run_done", bus.Run_Done, 1);
        check("iter0_start", bus.Computation_Start, 0);
        wait_idle(20);
        check("iter0_start_pulses", n_rise - r0, 0);
        check("iter0_run_done_pulses", n_rd - rd0, 1);
        read_reg(A_STAT, 32'h0000_0002, "iter0_status");

        // Timeout in ASSERT: Done never rises.
        rsp_en = 1'b0;
        write_reg(A_ITER, 32'd1);
        rd0 = n_rd;
        push_run(1, TMO);
        write_reg(A_CTRL, 32'h1);
        wait_idle(100);
        check("tmo_no_run_done", n_rd - rd0, 0);
        read_reg(A_STAT, 32'h0000_0004, "tmo_status");
        read_reg(A_CYC, 32'(TMO), "tmo_cycles");
        rsp_en = 1'b1;

        // ABORT together with GO in IDLE: nothing starts.
        write_reg(A_CTRL, 32'h3);
        check("abort_go_idle_start", bus.Computation_Start, 0);
        check("abort_go_idle_busy", bus.Launcher_Busy, 0);

        // ABORT during RELEASE of iteration 2 of 4.
        write_reg(A_ITER, 32'd4);
        push_run(2, RISE);
        write_reg(A_CTRL, 32'h1);
        prev_s = bus.Computation_Start;
        falls  = 0;
        k      = 0;
        while ((falls < 2) && (k < 200)) begin
            @(negedge Clk);
            if (prev_s && !bus.Computation_Start) falls++;
            prev_s = bus.Computation_Start;
            k++;
        end
        if (k >= 200) check("abort_wait_budget", falls, 2);
        write_reg(A_CTRL, 32'h2);
        check("abort_start", bus.Computation_Start, 0);
        check("abort_busy", bus.Launcher_Busy, 0);
        check("abort_iter_index", bus.Iter_Index, 1);
        repeat (3) @(negedge Clk);
        check("abort_start_stays_low", bus.Computation_Start, 0);
        read_reg(A_STAT, 32'h0001_0004, "abort_status");

        // GO with CLR: fresh four-iteration run.
        rd0 = n_rd;
        push_run(4, RISE);
        write_reg(A_CTRL, 32'h5);
        check("fresh_iter_index", bus.Iter_Index, 0);
        check("fresh_start", bus.Computation_Start, 1);
        wait_idle(300);
        check("fresh_run_done_pulses", n_rd - rd0, 1);
        read_reg(A_STAT, 32'h0004_0002, "fresh_status");

        // Stale Done already high when ASSERT is entered.
        stale = 1'b1;
        write_reg(A_ITER, 32'd1);
        push_run(1, 1);
        write_reg(A_CTRL, 32'h1);
        stale = 1'b0;
        wait_idle(50);
        read_reg(A_STAT, 32'h0001_0002, "stale_status");

        // ITER_NUM write and second GO while busy are dropped.
        write_reg(A_ITER, 32'd2);
        rd0 = n_rd;
        push_run(2, RISE);
        write_reg(A_CTRL, 32'h1);
        write_reg(A_ITER, 32'd7);
        write_reg(A_CTRL, 32'h1);
        wait_idle(200);
        check("busy_wr_run_done_pulses", n_rd - rd0, 1);
        read_reg(A_ITER, 32'd2, "busy_wr_iter_num");
        read_reg(A_STAT, 32'h0002_0002, "busy_wr_status");

        // Reset pulse during ASSERT.
        write_reg(A_ITER, 32'd3);
        rd0 = n_rd;
        push_run(1, 3);
        write_reg(A_CTRL, 32'h1);
        repeat (2) @(negedge Clk);
        #2;
        Resetn = 1'b0;
        #1;
        check("rst_mid_start_same_cycle", bus.Computation_Start, 0);
        @(negedge Clk);
        check("rst_mid_start", bus.Computation_Start, 0);
        check("rst_mid_busy", bus.Launcher_Busy, 0);
        check("rst_mid_run_done", bus.Run_Done, 0);
        check("rst_mid_iter_index", bus.Iter_Index, 0);
        check("rst_mid_rdata", bus.Cfg_Rdata, 0);
        Resetn = 1'b1;
        @(negedge Clk);
        read_reg(A_ITER, 32'd0, "rst_mid_iter_num");
        read_reg(A_STAT, 32'd0, "rst_mid_status");
        repeat (4) @(negedge Clk);
        check("rst_mid_no_run_done", n_rd - rd0, 0);

        check("width_queue_drained", exp_w_q.size(), 0);
        check("gap_queue_drained", exp_g_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
